rst_sequencer: RTL
==================

// Module: rst_sequencer
// PURPOSE
//  Board-level reset sequencer; drives the rst_i/rst_s input of all clk_i-domain logic (blinkers, counters).
//  Takes the external async active-low reset and the PLL lock flag, and produces registered active-high resets.
//  Reset assertion is asynchronous; release is synchronous and happens only after lock is stable.
//  Release is staged: early rst_o for core logic, later rst_late_o for consumers of core outputs, plus ready_o.
// PARAMETERS
//  SYNC_STAGES  2   flops in each synchroniser (reset release, pll_lock_i); legal >=2
//  LOCK_FILT    4   consecutive synced-high lock samples before lock counts as stable; >=1
//  HOLD_CYCLES  8   cycles spent in HOLD after stable lock, before rst_o is released; >=1
//  STAGE_GAP    4   cycles between the rst_o release and the rst_late_o/ready_o release; >=1
//  USE_LOCK     1   0: pll_lock_i is ignored and treated as constant 1
// PORTS
//  clk_i        in   1  system clock
//  rst_n_i      in   1  external reset, asynchronous, active-low
//  pll_lock_i   in   1  PLL lock, asynchronous to clk_i
//  rst_o        out  1  early reset, active-high, registered
//  rst_late_o   out  1  late reset, active-high, registered
//  ready_o      out  1  high only in RUN, registered
// BEHAVIOUR
//  Async reset:
//   - rst_n_i low immediately clears both sync chains, lock_cnt, the phase counter, and the state (state=RESET).
//   - Outputs go to rst_o=1, rst_late_o=1, ready_o=0, with no clock required. Applies mid-sequence and in RUN.
//  Reset sync chain: shifts in 1 each edge. rst_sync = last stage, high SYNC_STAGES edges after rst_n_i rises.
//  Lock sync chain:
//   - pll_lock_i goes through SYNC_STAGES flops to give lock_s.
//   - lock_cnt increments on every edge with lock_s=1 and saturates at LOCK_FILT.
//   - lock_cnt clears on any edge with lock_s=0.
//   - lock_ok = (lock_cnt==LOCK_FILT).
//  FSM (registered; phase counter cleared on every state entry):
//   - RESET -> WAIT_LOCK when rst_sync=1.
//   - WAIT_LOCK -> HOLD when lock_ok=1.
//   - HOLD counts 0..HOLD_CYCLES-1. On the edge where cnt==HOLD_CYCLES-1 -> STAGE.
//   - STAGE counts 0..STAGE_GAP-1. On cnt==STAGE_GAP-1 -> RUN. RUN is terminal while lock holds.
//   - lock_s==0 in HOLD, STAGE or RUN -> WAIT_LOCK next edge. Loss is deliberately unfiltered.
//   - Loss takes priority over a same-edge counter-terminal transition.
//  Outputs are registered from the next state, so they change on the same edge as the state:
//   - rst_o = 0 iff next state is STAGE or RUN.
//   - rst_late_o = 0 and ready_o = 1 iff next state is RUN.
//  Timing, lock already high, edge 1 = first edge after rst_n_i rises:
//   - rst_o falls at edge SYNC_STAGES+LOCK_FILT+1+HOLD_CYCLES (15 at defaults).
//   - rst_late_o falls and ready_o rises at edge +STAGE_GAP (19 at defaults).
//  Lock loss: first edge that samples pll_lock_i=0 = edge a. All three outputs re-assert at edge a+SYNC_STAGES.
//   The full LOCK_FILT/HOLD/STAGE sequence is then repeated.
//  Widths: counters are $clog2(max+1) bits, never wrap. Outputs never glitch: each is a single flop.
// TESTING
//  1 Defaults, lock held 1, rst_n_i 0->1 -> rst_o falls at edge 15; rst_late_o 0 and ready_o 1 at edge 19.
//  2 rst_n_i pulsed low in RUN, mid-cycle -> all outputs reset with no clock edge; edge-19 sequence repeats on release.
//  3 Lock high, one-cycle low glitch while in WAIT_LOCK -> lock_cnt restarts; rst_o falls 15 edges after the glitch's sync'd recovery.
//  4 pll_lock_i falls in RUN (edge a) -> rst_o=rst_late_o=1, ready_o=0 at edge a+2; relock re-runs LOCK_FILT+HOLD+STAGE.
//  5 Lock drops on the HOLD terminal edge -> goes to WAIT_LOCK, not STAGE; rst_o never deasserts.
//  6 USE_LOCK=0, pll_lock_i tied 0 -> same timing as scenario 1; lock toggling has no effect.

Source files
------------

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - staged reset sequencer: async assert, lock-qualified synchronous release.
module rst_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILT   = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGE_GAP   = 4,
  parameter int USE_LOCK    = 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic pll_lock_i,
  output logic rst_o,
  output logic rst_late_o,
  output logic ready_o
);

  localparam int LCNT_W = $clog2(LOCK_FILT + 1);
  localparam int PH_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT_LOCK,
    S_HOLD,
    S_STAGE,
    S_RUN
  } state_t;

  logic [SYNC_STAGES-1:0] r_rst_sync;
  logic [SYNC_STAGES-1:0] r_lock_sync;
  logic [LCNT_W-1:0]      r_lock_cnt;
  logic [PH_W-1:0]        r_cnt;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_lock_in;
  logic                   w_rst_sync;
  logic                   w_lock_s;
  logic                   w_lock_ok;
  logic                   w_hold_end;
  logic                   w_stage_end;

  assign w_lock_in   = (USE_LOCK != 0) ? pll_lock_i : 1'b1;
  assign w_rst_sync  = r_rst_sync[SYNC_STAGES-1];
  assign w_lock_s    = r_lock_sync[SYNC_STAGES-1];
  assign w_lock_ok   = (r_lock_cnt == LCNT_W'(LOCK_FILT));
  assign w_hold_end  = (r_cnt == PH_W'(HOLD_CYCLES - 1));
  assign w_stage_end = (r_cnt == PH_W'(STAGE_GAP - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rst_sync  <= '0;
      r_lock_sync <= '0;
      r_lock_cnt  <= '0;
    end else begin
      r_rst_sync  <= {r_rst_sync[SYNC_STAGES-2:0], 1'b1};
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], w_lock_in};
      if (!w_lock_s)
        r_lock_cnt <= '0;
      else if (!w_lock_ok)
        r_lock_cnt <= r_lock_cnt + LCNT_W'(1);
    end
  end

  // Lock loss is checked before the phase counter so it wins on a terminal edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RESET:     if (w_rst_sync) w_state_nxt = S_WAIT_LOCK;
      S_WAIT_LOCK: if (w_lock_ok)  w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (!w_lock_s)       w_state_nxt = S_WAIT_LOCK;
        else if (w_hold_end) w_state_nxt = S_STAGE;
      end
      S_STAGE: begin
        if (!w_lock_s)        w_state_nxt = S_WAIT_LOCK;
        else if (w_stage_end) w_state_nxt = S_RUN;
      end
      S_RUN:       if (!w_lock_s)  w_state_nxt = S_WAIT_LOCK;
      default:     w_state_nxt = S_RESET;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_RESET;
      r_cnt      <= '0;
      rst_o      <= 1'b1;
      rst_late_o <= 1'b1;
      ready_o    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state)
        r_cnt <= '0;
      else if (r_state == S_HOLD || r_state == S_STAGE)
        r_cnt <= r_cnt + PH_W'(1);
      rst_o      <= !(w_state_nxt == S_STAGE || w_state_nxt == S_RUN);
      rst_late_o <= (w_state_nxt != S_RUN);
      ready_o    <= (w_state_nxt == S_RUN);
    end
  end

endmodule
